// File: rtl/sw_pkg.sv
// Shared definitions for the host-to-core sequence path.
// - base_t       : 2-bit nucleotide code presented to the Smith-Waterman array
// - decode_t     : result of decoding one ASCII sequence character
// - HDR_*        : ASCII header bytes that open a target or a query frame
// - ERR_*        : bit positions inside the sticky error vector
// - decode_base  : case-insensitive A/C/G/T decoder; any other byte maps to A with ok=0
package sw_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  typedef struct packed {
    logic  ok;
    base_t base;
  } decode_t;

  localparam logic [7:0] HDR_TARGET = 8'h54;  // 'T'
  localparam logic [7:0] HDR_QUERY  = 8'h51;  // 'Q'

  localparam int ERR_FRAMING  = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_BAD_LEN  = 2;
  localparam int ERR_BAD_CHAR = 3;

  function automatic decode_t decode_base(input logic [7:0] ch);
    decode_t d;
    d.ok   = 1'b1;
    d.base = BASE_A;
    case (ch)
      8'h41, 8'h61: d.base = BASE_A;
      8'h43, 8'h63: d.base = BASE_C;
      8'h47, 8'h67: d.base = BASE_G;
      8'h54, 8'h74: d.base = BASE_T;
      default:      d.ok   = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   rxd         : asynchronous serial line, idle high
//   byte_data   : last received byte (valid while byte_valid is high)
//   byte_valid  : one-cycle strobe, byte received with a good stop bit
//   frame_err   : one-cycle strobe, stop bit sampled low (byte dropped)
// The strobes are registered, so they appear one cycle after the stop-bit sample.
module uart_rx #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detection.
  // All stages reset high so reset never looks like a start bit.
  logic [2:0]       sync_reg;
  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic             byte_valid_reg;
  logic             frame_err_reg;

  logic rxd_sync;
  logic rxd_prev;
  assign rxd_sync = sync_reg[1];
  assign rxd_prev = sync_reg[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg       <= 3'b111;
      state_reg      <= RX_IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[1:0], rxd};
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            state_reg <= RX_START;
            cnt_reg   <= '0;
          end
        end
        RX_START: begin
          // Mid-start check rejects glitches shorter than half a bit.
          if (cnt_reg == CNT_W'(HALF - 1)) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            state_reg <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == CNT_W'(DIV - 1)) begin
            cnt_reg   <= '0;
            shift_reg <= {rxd_sync, shift_reg[7:1]};  // LSB arrives first
            bit_reg   <= bit_reg + 1'b1;
            if (bit_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin  // RX_STOP
          if (cnt_reg == CNT_W'(DIV - 1)) begin
            cnt_reg        <= '0;
            state_reg      <= RX_IDLE;
            byte_valid_reg <= rxd_sync;
            frame_err_reg  <= !rxd_sync;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign byte_data  = shift_reg;
  assign byte_valid = byte_valid_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/uart_seq_loader.sv
// Host-to-core sequence loader: UART bytes -> byte FIFO -> frame parser -> base stream.
// Frame format: 'T' or 'Q', 16-bit big-endian length L, then L ASCII bases.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   i_rxd        : serial input, 8N1, idle high
//   o_valid/i_ready : base stream handshake
//   o_base       : A=0 C=1 G=2 T=3
//   o_is_query   : 1 for query frame, 0 for target frame
//   o_last       : final base of the frame
//   o_busy       : parser mid-frame or FIFO holds bytes
//   o_err        : sticky [0] framing, [1] overflow, [2] bad length, [3] bad char
//   i_err_clr    : clears o_err; a new error in the same cycle still sets its bit
module uart_seq_loader #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int MAX_LEN    = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [1:0] o_base,
  output logic       o_is_query,
  output logic       o_last,
  output logic       o_busy,
  output logic [3:0] o_err,
  input  logic       i_err_clr
);
  import sw_pkg::*;

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] P_IDLE   = 2'd0;
  localparam logic [1:0] P_LEN_HI = 2'd1;
  localparam logic [1:0] P_LEN_LO = 2'd2;
  localparam logic [1:0] P_DATA   = 2'd3;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (i_rxd),
    .byte_data  (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_frame_err)
  );

  // Byte FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_reg;
  logic [PTR_W:0] rd_ptr_reg;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           overflow;
  logic [7:0]     pop_data;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push       = rx_valid && (!fifo_full || pop);
  assign overflow   = rx_valid && fifo_full && !pop;
  assign pop_data   = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Parser and output register
  logic [1:0]  state_reg, state_next;
  logic        frame_query_reg, frame_query_next;
  logic [7:0]  len_hi_reg, len_hi_next;
  logic [15:0] remain_reg, remain_next;
  logic        valid_reg, valid_next;
  logic [1:0]  base_reg, base_next;
  logic        query_reg, query_next;
  logic        last_reg, last_next;
  logic [3:0]  err_reg, err_next;

  logic        can_accept;
  logic [15:0] len_word;
  decode_t     dec;

  // In DATA a pop must land in the output register, so it waits for a free slot.
  assign can_accept = (state_reg != P_DATA) || !valid_reg || i_ready;
  assign pop        = !fifo_empty && can_accept;
  assign len_word   = {len_hi_reg, pop_data};
  assign dec        = decode_base(pop_data);

  always_comb begin
    state_next       = state_reg;
    frame_query_next = frame_query_reg;
    len_hi_next      = len_hi_reg;
    remain_next      = remain_reg;
    valid_next       = valid_reg;
    base_next        = base_reg;
    query_next       = query_reg;
    last_next        = last_reg;
    err_next         = i_err_clr ? 4'd0 : err_reg;

    if (valid_reg && i_ready) valid_next = 1'b0;
    if (rx_frame_err) err_next[ERR_FRAMING]  = 1'b1;
    if (overflow)     err_next[ERR_OVERFLOW] = 1'b1;

    if (pop) begin
      case (state_reg)
        P_IDLE: begin
          if (pop_data == HDR_TARGET) begin
            frame_query_next = 1'b0;
            state_next       = P_LEN_HI;
          end else if (pop_data == HDR_QUERY) begin
            frame_query_next = 1'b1;
            state_next       = P_LEN_HI;
          end
        end
        P_LEN_HI: begin
          len_hi_next = pop_data;
          state_next  = P_LEN_LO;
        end
        P_LEN_LO: begin
          if (len_word == 16'd0) begin
            state_next = P_IDLE;
          end else if (len_word > 16'(MAX_LEN)) begin
            err_next[ERR_BAD_LEN] = 1'b1;
            state_next            = P_IDLE;
          end else begin
            remain_next = len_word;
            state_next  = P_DATA;
          end
        end
        default: begin  // P_DATA
          valid_next  = 1'b1;
          base_next   = dec.base;
          query_next  = frame_query_reg;
          last_next   = (remain_reg == 16'd1);
          remain_next = remain_reg - 16'd1;
          if (!dec.ok) err_next[ERR_BAD_CHAR] = 1'b1;
          if (remain_reg == 16'd1) state_next = P_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= P_IDLE;
      frame_query_reg <= 1'b0;
      len_hi_reg      <= '0;
      remain_reg      <= '0;
      valid_reg       <= 1'b0;
      base_reg        <= '0;
      query_reg       <= 1'b0;
      last_reg        <= 1'b0;
      err_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      frame_query_reg <= frame_query_next;
      len_hi_reg      <= len_hi_next;
      remain_reg      <= remain_next;
      valid_reg       <= valid_next;
      base_reg        <= base_next;
      query_reg       <= query_next;
      last_reg        <= last_next;
      err_reg         <= err_next;
    end
  end

  assign o_valid    = valid_reg;
  assign o_base     = base_reg;
  assign o_is_query = query_reg;
  assign o_last     = last_reg;
  assign o_err      = err_reg;
  assign o_busy     = (state_reg != P_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_seq_loader.sv
module tb_uart_seq_loader;

  // 115200 baud with a scaled clock keeps a bit period at 10 cycles.
  localparam int CLK_FREQ   = 1_152_000;
  localparam int BAUD       = 115200;
  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int MAX_LEN    = 1024;
  localparam int FIFO_DEPTH = 8;

  typedef logic [7:0] bytes_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rxd = 1'b1;
  logic       i_ready;
  logic       i_err_clr = 1'b0;
  logic       o_valid;
  logic [1:0] o_base;
  logic       o_is_query;
  logic       o_last;
  logic       o_busy;
  logic [3:0] o_err;

  int         ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random
  int         errors = 0;
  int         checks = 0;
  logic [3:0] got_q [$];        // {is_query, last, base}
  logic [3:0] exp_q [$];
  logic [3:0] exp_err = 4'd0;

  always #5 clk = ~clk;

  uart_seq_loader #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .MAX_LEN    (MAX_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rxd      (i_rxd),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_base     (o_base),
    .o_is_query (o_is_query),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .i_err_clr  (i_err_clr)
  );

  initial begin : ready_driver
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_ready = 1'b0;
        1:       i_ready = 1'b1;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Record every handshake; it completes at the following rising edge.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      got_q.push_back({o_is_query, o_last, o_base});
      $display("xfer %0d: base=%0d query=%0b last=%0b err=%b",
               got_q.size(), o_base, o_is_query, o_last, o_err);
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  task automatic uart_bit(input logic v);
    i_rxd = v;
    tick(DIV);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_bit(1'b0);
    for (int k = 0; k < 8; k++) uart_bit(b[k]);
    uart_bit(stop_ok);
    uart_bit(1'b1);
  endtask

  task automatic send_seq(input bytes_t s);
    foreach (s[k]) send_byte(s[k], 1'b1);
  endtask

  function automatic bytes_t build_frame(input logic [7:0] hdr, input logic [15:0] len, input string body);
    bytes_t s;
    s.push_back(hdr);
    s.push_back(len[15:8]);
    s.push_back(len[7:0]);
    for (int k = 0; k < body.len(); k++) s.push_back(body[k]);
    return s;
  endfunction

  // Reference: walk a complete byte stream frame by frame and list the bases it must produce.
  task automatic model_stream(input bytes_t s);
    int         i = 0;
    int         len;
    logic       q;
    logic [7:0] c;
    logic [1:0] b;
    while (i < s.size()) begin
      if (s[i] == 8'h54 || s[i] == 8'h51) begin
        q   = (s[i] == 8'h51);
        len = int'(s[i+1]) * 256 + int'(s[i+2]);
        i   = i + 3;
        if (len > MAX_LEN) begin
          exp_err[2] = 1'b1;
        end else begin
          for (int k = 0; k < len; k++) begin
            c = s[i+k];
            if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
            case (c)
              8'h41:   b = 2'd0;
              8'h43:   b = 2'd1;
              8'h47:   b = 2'd2;
              8'h54:   b = 2'd3;
              default: begin b = 2'd0; exp_err[3] = 1'b1; end
            endcase
            exp_q.push_back({q, (k == len - 1), b});
          end
          i = i + len;
        end
      end else begin
        i = i + 1;
      end
    end
  endtask

  task automatic drain(input string tag, input bit need_idle);
    int n = 0;
    while (n < 3000 && !(got_q.size() >= exp_q.size() && !o_valid && (!need_idle || !o_busy))) begin
      tick();
      n++;
    end
    check({tag, " drain in time"}, 32'(n < 3000), 32'd1);
    check({tag, " base count"}, got_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      check($sformatf("%s base %0d", tag, k),
            32'((k < got_q.size()) ? got_q[k] : 4'hx), 32'(exp_q[k]));
    end
    check({tag, " err"}, 32'(o_err), 32'(exp_err));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_err(input string tag);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    exp_err   = 4'd0;
    tick();
    check(tag, 32'(o_err), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " o_valid"},    32'(o_valid),    32'd0);
    check({tag, " o_base"},     32'(o_base),     32'd0);
    check({tag, " o_is_query"}, 32'(o_is_query), 32'd0);
    check({tag, " o_last"},     32'(o_last),     32'd0);
    check({tag, " o_busy"},     32'(o_busy),     32'd0);
    check({tag, " o_err"},      32'(o_err),      32'd0);
  endtask

  initial begin : main
    bytes_t s;
    string  alphabet;
    string  body;
    int     busy_seen;
    int     len;

    alphabet = "ACGTacgtN";

    // Reset state
    rst = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Basic target frame
    s = build_frame(8'h54, 16'd4, "ACGT");
    send_seq(s);
    model_stream(s);
    drain("target ACGT", 1'b1);

    // Lower case and an illegal character in a query frame
    s = build_frame(8'h51, 16'd3, "gtN");
    send_seq(s);
    model_stream(s);
    drain("query gtN", 1'b1);
    clear_err("err clear after bad char");

    // Stalled sink: one base held in the output register, FIFO fills, rest dropped
    ready_mode = 0;
    tick(3);
    body = "";
    for (int k = 0; k < 12; k++) body = {body, string'(alphabet[$urandom_range(0, 3)])};
    s = build_frame(8'h51, 16'd12, body);
    send_seq(s);
    tick(5);
    model_stream(s);
    while (exp_q.size() > 1 + FIFO_DEPTH) void'(exp_q.pop_back());
    exp_err = 4'b0010;
    check("stall o_valid held", 32'(o_valid), 32'd1);
    check("stall payload held", 32'({o_is_query, o_last, o_base}), 32'(exp_q[0]));
    check("stall no handshake", got_q.size(), 0);
    check("stall overflow err", 32'(o_err), 32'(exp_err));
    ready_mode = 1;
    drain("stall drain", 1'b0);
    check("stall frame still open", 32'(o_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 4'd0;
    tick();
    check("stall reset busy", 32'(o_busy), 32'd0);
    check("stall reset err", 32'(o_err), 32'd0);

    // Oversized length, then a legal one-base frame
    s = build_frame(8'h54, 16'd1025, "");
    s = {s, build_frame(8'h54, 16'd1, "C")};
    send_seq(s);
    model_stream(s);
    drain("bad length then C", 1'b1);
    clear_err("err clear after bad length");

    // Stop bit low: framing error, nothing enters the FIFO
    send_byte(8'h54, 1'b0);
    tick(5);
    check("bad stop err", 32'(o_err), 32'b0001);
    check("bad stop no push", 32'(o_busy), 32'd0);
    clear_err("err clear after framing");

    // Start glitch shorter than half a bit
    i_rxd = 1'b0;
    tick(2);
    i_rxd = 1'b1;
    busy_seen = 0;
    repeat (15 * DIV) begin
      tick();
      if (o_busy) busy_seen++;
    end
    check("glitch busy cycles", busy_seen, 0);
    check("glitch err", 32'(o_err), 32'd0);

    // Reset after 2 of 4 data bytes
    s = build_frame(8'h54, 16'd4, "AC");
    send_seq(s);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
    drain("partial frame", 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs("reset mid-frame");
    rst = 1'b0;
    tick(2);
    s = build_frame(8'h54, 16'd4, "TGCA");
    send_seq(s);
    model_stream(s);
    drain("frame after reset", 1'b1);

    // Random frames with line noise and a randomly stalling sink
    ready_mode = 2;
    for (int it = 0; it < 8; it++) begin
      s.delete();
      if ($urandom_range(0, 1) == 1) begin
        s.push_back(8'h0D);
        s.push_back(8'h0A);
      end
      len = $urandom_range(0, 16);
      s.push_back(($urandom_range(0, 1) == 1) ? 8'h51 : 8'h54);
      s.push_back(8'(len >> 8));
      s.push_back(8'(len));
      for (int k = 0; k < len; k++) s.push_back(alphabet[$urandom_range(0, 8)]);
      send_seq(s);
      model_stream(s);
      drain($sformatf("random frame %0d", it), 1'b1);
      clear_err($sformatf("random err clear %0d", it));
    end
    ready_mode = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
